// File: rtl/if_id_buffer.sv
// IF/ID decoupling stage: small circular FIFO of {PC, instruction} pairs with valid/ready on both sides.
// Optional macro IF_ID_BUBBLE_NOP_EN: drive NOP_INST on id_inst whenever id_valid is low.
module if_id_buffer #(
    parameter int                   DataWidth = 32,
    parameter int                   DEPTH     = 2,
    parameter logic [DataWidth-1:0] NOP_INST  = DataWidth'(32'h0000_0013)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 if_valid,
    input  logic [DataWidth-1:0] if_pc,
    input  logic [DataWidth-1:0] if_inst,
    output logic                 if_ready,
    input  logic                 id_ready,
    output logic                 id_valid,
    output logic [DataWidth-1:0] id_pc,
    output logic [DataWidth-1:0] id_inst,
    output logic [DataWidth-1:0] id_pc_plus4
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

`ifdef IF_ID_BUBBLE_NOP_EN
    localparam bit BUBBLE_NOP = 1'b1;
`else
    localparam bit BUBBLE_NOP = 1'b0;
`endif
    localparam logic [DataWidth-1:0] EMPTY_INST = NOP_INST & {DataWidth{BUBBLE_NOP}};

    logic [DataWidth-1:0] pc_q   [DEPTH];
    logic [DataWidth-1:0] inst_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic full;

    // Ready depends only on the registered count, never on id_ready.
    assign full     = (count_q == CW'(DEPTH));
    assign if_ready = !full;
    assign id_valid = (count_q != '0);

    assign push = if_valid && if_ready;
    assign pop  = id_valid && id_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is never reset; stale data is masked at the outputs.
    always_ff @(posedge clock) begin
        if (reset && !flush && push) begin
            pc_q[wr_ptr_q]   <= if_pc;
            inst_q[wr_ptr_q] <= if_inst;
        end
    end

    always_comb begin
        id_pc   = '0;
        id_inst = EMPTY_INST;
        if (id_valid) begin
            id_pc   = pc_q[rd_ptr_q];
            id_inst = inst_q[rd_ptr_q];
        end
    end

    assign id_pc_plus4 = id_pc + DataWidth'(4);

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: accepted pushes are queued, the head is compared every cycle and popped on handshake.
module tb_if_id_buffer;

    localparam int DEPTH = 2;

`ifdef IF_ID_BUBBLE_NOP_EN
    localparam logic [31:0] EMPTY_INST = 32'h0000_0013;
`else
    localparam logic [31:0] EMPTY_INST = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;

    entry_t sb[$];
    int     total = 0;
    int     bad = 0;
    bit     armed = 1'b0;

    if_id_buffer #(.DataWidth(32), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_ready    (if_ready),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_pc_plus4 (id_pc_plus4)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (sb.size() > 0) ? sb[0].pc : 32'h0;
        e_inst = (sb.size() > 0) ? sb[0].inst : EMPTY_INST;
        check_val("if_ready", {31'b0, if_ready}, {31'b0, sb.size() < DEPTH});
        check_val("id_valid", {31'b0, id_valid}, {31'b0, sb.size() > 0});
        check_val("id_pc", id_pc, e_pc);
        check_val("id_inst", id_inst, e_inst);
        check_val("id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, update the model at the rising edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, input logic rst);
        bit acc;
        bit popx;
        @(negedge clock);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        reset    = rst;
        #1;
        if (armed) check_outputs();
        acc  = v && (sb.size() < DEPTH);
        popx = rdy && (sb.size() > 0);
        @(posedge clock);
        if (!rst || fl) begin
            sb.delete();
            $display("clear rst=%0b flush=%0b", rst, fl);
            if (!rst) armed = 1'b1;
        end else begin
            if (popx) begin
                $display("pop  pc=%08h inst=%08h", sb[0].pc, sb[0].inst);
                void'(sb.pop_front());
            end
            if (acc) begin
                sb.push_back('{pc: pc, inst: inst});
                $display("push pc=%08h inst=%08h", pc, inst);
            end else if (v) begin
                $display("push refused pc=%08h", pc);
            end
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        // reset held for two edges, then idle to observe reset values
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);

        // streaming
        cycle(1'b1, 32'h0, 32'h0050_0093, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h4, 32'h0010_8113, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h8, 32'h0021_01B3, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);

        // stall until full, refused third push, then drain
        cycle(1'b1, 32'h10, 32'hAAAA_0010, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h14, 32'hAAAA_0014, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h18, 32'hAAAA_0018, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 3);

        // wrap-around with alternating stalls
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), (i % 2) == 1, 1'b0, 1'b1);
        idle(1'b1, 3);

        // flush with a concurrent push and pop
        cycle(1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h24, 32'hC000_0024, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h28, 32'hC000_0028, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h40, 32'hC000_0040, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // PC+4 wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 32'hD000_0001, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // reset while full and stalled
        cycle(1'b1, 32'h50, 32'hE000_0050, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h54, 32'hE000_0054, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 3);

        // random traffic
        for (int i = 0; i < 60; i++)
            cycle($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 1'b1);
        idle(1'b1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
